// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin arbiter.
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/arb_rr_8_rr_pick.sv
// Round-robin picker: first set req bit scanning ptr, ptr+1, ... ptr+7 (mod 8).
// Purely combinational, no latency; no flow control.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest hit to ptr is written last.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/arb_rr_8.sv
// 8-way round-robin arbiter with done-based release and MAX_HOLD forced timeout.
// Grant latency 1 cycle from req in IDLE; no backpressure, one idle gap cycle after each release.
module arb_rr_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);
    localparam int HW = $clog2(MAX_HOLD);

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [HW-1:0]    hold_cnt, hold_n;
    logic [IDX_W-1:0] gnt_idx_n;
    logic             gnt_valid_n;
    logic             timeout_n;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_n;
            gnt_idx   <= gnt_idx_n;
            gnt_valid <= gnt_valid_n;
            timeout   <= timeout_n;
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        hold_n      = hold_cnt;
        gnt_idx_n   = gnt_idx;
        gnt_valid_n = 1'b0;
        timeout_n   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    gnt_idx_n   = pick_idx;
                    gnt_valid_n = 1'b1;
                    hold_n      = '0;
                    state_n     = BUSY;
                end
            end
            BUSY: begin
                // done takes priority, so a same-cycle timeout never pulses.
                if (done || (hold_cnt == HW'(MAX_HOLD - 1))) begin
                    ptr_n     = gnt_idx + IDX_W'(1);
                    state_n   = IDLE;
                    timeout_n = ~done;
                end else begin
                    gnt_valid_n = 1'b1;
                    hold_n      = hold_cnt + HW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_arb_rr_8.sv
// Directed bench for arb_rr_8 with MAX_HOLD=4; expectations are hand-computed.
module tb_arb_rr_8;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int passed = 0;
    int total  = 0;

    arb_rr_8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b0;
        req  = 8'h00;
        done = 1'b0;

        // Async reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", {7'b0, gnt_valid}, 8'h00);
        chk("rst_idx", {5'b0, gnt_idx}, 8'h00);
        chk("rst_timeout", {7'b0, timeout}, 8'h00);
        tick();
        tick();
        chk("rst_hold_valid", {7'b0, gnt_valid}, 8'h00);
        rst = 1'b0;

        // Single requester, then ptr=1 proven by req=03 picking 1
        req = 8'h01;
        tick();
        chk("r01_valid", {7'b0, gnt_valid}, 8'h01);
        chk("r01_idx", {5'b0, gnt_idx}, 8'h00);
        done = 1'b1;
        tick();
        chk("r01_rel_valid", {7'b0, gnt_valid}, 8'h00);
        chk("r01_rel_timeout", {7'b0, timeout}, 8'h00);
        done = 1'b0;
        req  = 8'h03;
        tick();
        chk("ptr1_idx", {5'b0, gnt_idx}, 8'h01);
        chk("ptr1_valid", {7'b0, gnt_valid}, 8'h01);
        done = 1'b1;
        req  = 8'h00;
        tick();
        chk("ptr1_rel_valid", {7'b0, gnt_valid}, 8'h00);
        tick();
        chk("done_in_idle", {7'b0, gnt_valid}, 8'h00);
        done = 1'b0;

        // Full rotation from ptr=0 with all requesters active
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("rot%0d_valid", i), {7'b0, gnt_valid}, 8'h01);
            chk($sformatf("rot%0d_idx", i), {5'b0, gnt_idx}, 8'(i % 8));
            done = 1'b1;
            tick();
            chk($sformatf("rot%0d_gap", i), {7'b0, gnt_valid}, 8'h00);
            done = 1'b0;
        end

        // ptr=1: grant 5 to move ptr to 6, then req=21 wraps to 0
        req = 8'h20;
        tick();
        chk("g5_idx", {5'b0, gnt_idx}, 8'h05);
        done = 1'b1;
        tick();
        chk("g5_gap", {7'b0, gnt_valid}, 8'h00);
        done = 1'b0;
        req  = 8'h21;
        tick();
        chk("wrap_idx", {5'b0, gnt_idx}, 8'h00);
        chk("wrap_valid", {7'b0, gnt_valid}, 8'h01);
        done = 1'b1;
        tick();
        chk("wrap_rel", {7'b0, gnt_valid}, 8'h00);
        done = 1'b0;

        // done in the 4th BUSY cycle beats the timeout
        req = 8'h08;
        tick();
        chk("h4_idx", {5'b0, gnt_idx}, 8'h03);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk($sformatf("h4_busy%0d", i), {7'b0, gnt_valid}, 8'h01);
        end
        done = 1'b1;
        tick();
        chk("h4_rel_valid", {7'b0, gnt_valid}, 8'h00);
        chk("h4_no_timeout", {7'b0, timeout}, 8'h00);
        done = 1'b0;

        // No done: grant lasts exactly 4 cycles, then a timeout pulse, then regrant
        tick();
        chk("to_grant_valid", {7'b0, gnt_valid}, 8'h01);
        chk("to_grant_idx", {5'b0, gnt_idx}, 8'h03);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk($sformatf("to_busy%0d", i), {7'b0, gnt_valid}, 8'h01);
            chk($sformatf("to_quiet%0d", i), {7'b0, timeout}, 8'h00);
        end
        tick();
        chk("to_rel_valid", {7'b0, gnt_valid}, 8'h00);
        chk("to_pulse", {7'b0, timeout}, 8'h01);
        tick();
        chk("to_regrant_valid", {7'b0, gnt_valid}, 8'h01);
        chk("to_regrant_idx", {5'b0, gnt_idx}, 8'h03);
        chk("to_pulse_end", {7'b0, timeout}, 8'h00);

        // Reset mid-grant drops the grant asynchronously, ptr returns to 0
        tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {7'b0, gnt_valid}, 8'h00);
        chk("mid_rst_idx", {5'b0, gnt_idx}, 8'h00);
        chk("mid_rst_timeout", {7'b0, timeout}, 8'h00);
        tick();
        rst = 1'b0;
        req = 8'h18;
        tick();
        chk("post_rst_valid", {7'b0, gnt_valid}, 8'h01);
        chk("post_rst_idx", {5'b0, gnt_idx}, 8'h03);
        chk("post_rst_timeout", {7'b0, timeout}, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/arb_rr_8.md
ARB_RR_8 -- requirements
Module: arb_rr_8

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of cycles a grant is held without done (legal range 2..256).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port req  input  8  request lines, bit i = requester i.
REQ-005 The block SHALL have port done  input  1  granted requester finished, sampled only in BUSY.
REQ-006 The block SHALL have port gnt_idx  output  3  binary index of the granted requester, which the downstream 3-to-8 decoder turns into a one-hot grant.
REQ-007 The block SHALL have port gnt_valid  output  1  gnt_idx is a live grant.
REQ-008 The block SHALL have port timeout  output  1  one-cycle pulse when a grant is force-released.
REQ-009 All outputs SHALL be driven directly from registers, with no combinational path from input to output.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-011 In IDLE with req != 0 at a clock edge, the block SHALL, at that edge, load gnt_idx with the first set req bit found scanning ptr, ptr+1, ... ptr+7 (mod 8), set gnt_valid=1, clear hold_cnt to 0 and enter BUSY; grant latency is 1 cycle.
REQ-012 In IDLE with req == 0, the block SHALL stay in IDLE with gnt_valid=0 and gnt_idx unchanged.
REQ-013 In BUSY, the block SHALL hold gnt_idx and gnt_valid=1 stable and increment hold_cnt once per cycle, regardless of changes on req.
REQ-014 In BUSY with done=1, the block SHALL, at that edge, set gnt_valid=0, set ptr=gnt_idx+1 (mod 8, so 7 wraps to 0) and enter IDLE.
REQ-015 In BUSY with done=0 and hold_cnt==MAX_HOLD-1, the block SHALL release exactly as in REQ-014 and also set timeout=1 for one cycle, so a grant never lasts more than MAX_HOLD cycles.
REQ-016 When done=1 and the timeout condition occur in the same cycle, done SHALL win and timeout SHALL stay 0.
REQ-017 done asserted while in IDLE SHALL be ignored.
REQ-018 After every release the block SHALL spend at least one cycle in IDLE, so consecutive grants are separated by exactly one cycle of gnt_valid=0 when requests are pending.
REQ-019 timeout SHALL be 0 in every cycle other than the one following a forced release.
REQ-020 hold_cnt SHALL be ceil(log2(MAX_HOLD)) bits wide and SHALL never wrap within one grant.

Reset
REQ-021 While rst=1, regardless of clk: state=IDLE, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0.
REQ-022 Reset asserted during BUSY SHALL drop the grant immediately, with no timeout pulse.
REQ-023 After rst is released, the first grant SHALL be decided at the first clk edge with req != 0, using ptr=0.

Structure
REQ-024 Package arb_pkg SHALL hold N_REQ=8, IDX_W=3 and the state enum {IDLE, BUSY}.
REQ-025 Sub-module rr_pick SHALL be purely combinational: inputs req[7:0] and ptr[2:0]; outputs idx[2:0] and any.
REQ-026 The FSM, ptr, hold_cnt and output registers SHALL live in arb_rr_8.

Verification
REQ-027 Reset then req=8'h01 -> one cycle later gnt_valid=1, gnt_idx=0; done pulse -> gnt_valid=0 next cycle and ptr=1.
REQ-028 req=8'hFF held, done pulsed after each grant -> gnt_idx sequence 0,1,2,...,7,0, with one gap cycle between grants.
REQ-029 ptr=6 (after granting 5), req=8'h21 -> gnt_idx=0, since the scan 6,7,0 wraps before reaching 5.
REQ-030 MAX_HOLD=4, req=8'h08, done never asserted -> gnt_valid high for exactly 4 cycles, then timeout=1 for 1 cycle; with req still 8'h08 it is granted again after the gap cycle.
REQ-031 MAX_HOLD=4, done=1 in the 4th BUSY cycle -> normal release, timeout stays 0.
REQ-032 rst pulsed mid-grant with gnt_idx=3 -> gnt_valid=0 and gnt_idx=0 asynchronously; after release with req=8'h18, the next grant is gnt_idx=3.
